img_host_if: RTL and testbench

IMG_HOST_IF -- requirements
Module: img_host_if

---
 rtl/img_host_if.sv | 199 +++++++++++++++++++
 tb/tb_img_host_if.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_host_if.sv
// img_host_if: host byte-stream front end for the image core.
//   Receives a 4-byte little-endian header (w, h) followed by w*h pixel bytes,
//   writes the pixels into mem_in, pulses core_start, waits for a core_done
//   rising edge, then streams mem_out[0 .. out_w*out_h-1] back to the host.
// Ports:
//   clk_50, rst_n            clock, async active-low reset
//   s_valid/s_ready/s_data   host -> block byte stream
//   in_we/in_waddr/in_wdata  mem_in write port
//   img_w, img_h             latched input dimensions
//   core_start/core_done     core handshake (pulse / level)
//   out_w, out_h             output dimensions from the core
//   out_raddr/out_rdata      mem_out read port (1-cycle read latency)
//   m_valid/m_ready/m_data   block -> host byte stream
//   busy, err_size           not-idle flag, sticky dimension error
module img_host_if #(
  parameter int AW = 12
) (
  input  logic          clk_50,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          in_we,
  output logic [AW-1:0] in_waddr,
  output logic [7:0]    in_wdata,
  output logic [15:0]   img_w,
  output logic [15:0]   img_h,
  output logic          core_start,
  input  logic          core_done,
  input  logic [15:0]   out_w,
  input  logic [15:0]   out_h,
  output logic [AW-1:0] out_raddr,
  input  logic [7:0]    out_rdata,
  output logic          m_valid,
  output logic [7:0]    m_data,
  input  logic          m_ready,
  output logic          busy,
  output logic          err_size
);

  localparam logic [32:0] MAX_PIX = 33'd1 << AW;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_START, S_WAIT, S_DUMP} state_t;
  state_t state, state_nxt;

  logic          rdy_en;      // holds s_ready low until the first edge after reset
  logic [1:0]    hdr_idx;
  logic [7:0]    hdr_b0, hdr_b1, hdr_b2;
  logic [31:0]   pix_cnt, pix_total;
  logic [31:0]   out_total, rd_cnt, sent_cnt;
  logic          done_q;
  logic          infl;        // read issued last cycle, data on out_rdata now
  logic [1:0]    fcnt;        // 2-entry output buffer occupancy
  logic [7:0]    f0, f1;      // f0 is the head presented on m_data
  logic [AW-1:0] raddr_q;

  logic          s_acc, pop, issue, done_rise;
  logic          hdr_bad, out_bad, last_pix, last_out;
  logic [15:0]   hdr_w, hdr_h;
  logic [31:0]   hdr_prod, out_prod;
  logic [2:0]    occ_nxt;

  assign s_ready   = rdy_en && (state == S_IDLE || state == S_HDR || state == S_LOAD);
  assign s_acc     = s_valid && s_ready;
  assign hdr_w     = {hdr_b1, hdr_b0};
  assign hdr_h     = {s_data, hdr_b2};
  assign hdr_prod  = 32'(hdr_w) * 32'(hdr_h);
  assign hdr_bad   = (hdr_w == 16'd0) || (hdr_h == 16'd0) || ({1'b0, hdr_prod} > MAX_PIX);
  assign out_prod  = 32'(out_w) * 32'(out_h);
  assign out_bad   = (out_prod == 32'd0) || ({1'b0, out_prod} > MAX_PIX);
  assign done_rise = core_done && !done_q;
  assign last_pix  = (pix_cnt == pix_total - 32'd1);
  assign last_out  = (sent_cnt == out_total - 32'd1);

  assign m_valid   = (fcnt != 2'd0);
  assign m_data    = f0;
  assign pop       = m_valid && m_ready;
  // Occupancy once this cycle's pop and in-flight read settle; a new read is
  // only issued if its data will still have a free slot next cycle.
  assign occ_nxt   = {1'b0, fcnt} + {2'b00, infl} - {2'b00, pop};
  assign issue     = (state == S_DUMP) && (rd_cnt < out_total) && (occ_nxt < 3'd2);
  // Hold the last issued address when idle so no read strays past the end.
  assign out_raddr = issue ? rd_cnt[AW-1:0] : raddr_q;

  assign in_waddr  = pix_cnt[AW-1:0];
  assign in_wdata  = s_data;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_we      = 1'b0;
    core_start = 1'b0;
    case (state)
      S_IDLE:  if (s_acc) state_nxt = S_HDR;
      S_HDR:   if (s_acc && hdr_idx == 2'd3) state_nxt = hdr_bad ? S_IDLE : S_LOAD;
      S_LOAD: begin
        in_we = s_acc;
        if (s_acc && last_pix) state_nxt = S_START;
      end
      S_START: begin
        core_start = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT:  if (done_rise) state_nxt = out_bad ? S_IDLE : S_DUMP;
      S_DUMP:  if (pop && last_out) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en    <= 1'b0;
      done_q    <= 1'b0;
      hdr_idx   <= 2'd0;
      hdr_b0    <= '0;
      hdr_b1    <= '0;
      hdr_b2    <= '0;
      img_w     <= '0;
      img_h     <= '0;
      err_size  <= 1'b0;
      pix_cnt   <= '0;
      pix_total <= '0;
      out_total <= '0;
      rd_cnt    <= '0;
      sent_cnt  <= '0;
      infl      <= 1'b0;
      fcnt      <= 2'd0;
      f0        <= '0;
      f1        <= '0;
      raddr_q   <= '0;
    end else begin
      rdy_en <= 1'b1;
      done_q <= core_done;
      case (state)
        S_IDLE: if (s_acc) begin
          hdr_b0  <= s_data;
          hdr_idx <= 2'd1;
        end
        S_HDR: if (s_acc) begin
          hdr_idx <= hdr_idx + 2'd1;
          case (hdr_idx)
            2'd1: hdr_b1 <= s_data;
            2'd2: hdr_b2 <= s_data;
            default: begin
              img_w     <= hdr_w;
              img_h     <= hdr_h;
              err_size  <= hdr_bad;
              pix_total <= hdr_prod;
              pix_cnt   <= '0;
            end
          endcase
        end
        S_LOAD: if (s_acc) pix_cnt <= pix_cnt + 32'd1;
        S_WAIT: if (done_rise) begin
          err_size  <= out_bad;
          out_total <= out_prod;
          rd_cnt    <= '0;
          sent_cnt  <= '0;
          infl      <= 1'b0;
          fcnt      <= 2'd0;
        end
        S_DUMP: begin
          infl <= issue;
          if (issue) begin
            rd_cnt  <= rd_cnt + 32'd1;
            raddr_q <= rd_cnt[AW-1:0];
          end
          if (pop) sent_cnt <= sent_cnt + 32'd1;
          case ({infl, pop})
            2'b10: begin
              if (fcnt == 2'd0) f0 <= out_rdata;
              else              f1 <= out_rdata;
              fcnt <= fcnt + 2'd1;
            end
            2'b01: begin
              f0   <= f1;
              fcnt <= fcnt - 2'd1;
            end
            2'b11: begin
              if (fcnt == 2'd1) f0 <= out_rdata;
              else begin
                f0 <= f1;
                f1 <= out_rdata;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_img_host_if.sv
// Bench for img_host_if: table vectors, randomized transfers checked against a
// dimension-rule model, and hand sequences for held core_done and mid-run reset.
module tb_img_host_if;
  localparam int AW   = 12;
  localparam int MEMN = 1 << AW;

  logic          clk_50 = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_ready;
  logic          in_we;
  logic [AW-1:0] in_waddr;
  logic [7:0]    in_wdata;
  logic [15:0]   img_w, img_h;
  logic          core_start, core_done;
  logic [15:0]   out_w = '0, out_h = '0;
  logic [AW-1:0] out_raddr;
  logic [7:0]    out_rdata = '0;
  logic          m_valid;
  logic [7:0]    m_data;
  logic          m_ready = 1'b0;
  logic          busy, err_size;

  img_host_if #(.AW(AW)) dut (
    .clk_50(clk_50), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .img_w(img_w), .img_h(img_h),
    .core_start(core_start), .core_done(core_done),
    .out_w(out_w), .out_h(out_h),
    .out_raddr(out_raddr), .out_rdata(out_rdata),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .err_size(err_size)
  );

  always #5 clk_50 = ~clk_50;

  // mem_out model: synchronous read, data one cycle after the address
  logic [7:0] mem_out [MEMN];
  always @(posedge clk_50) out_rdata <= mem_out[out_raddr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- monitors ----------------
  logic [AW-1:0] got_wa[$];
  logic [7:0]    got_wd[$];
  logic [7:0]    got_m[$];
  int            start_cnt = 0;
  int            bubbles = 0;
  int            exp_n_out = 0;

  always @(negedge clk_50) begin
    if (in_we) begin
      got_wa.push_back(in_waddr);
      got_wd.push_back(in_wdata);
    end
    if (core_start) start_cnt++;
    if (m_valid && m_ready) got_m.push_back(m_data);
    else if (!m_valid && busy && got_m.size() > 0 && got_m.size() < exp_n_out) bubbles++;
  end

  // ---------------- core model ----------------
  logic auto_val = 1'b0, man_val = 1'b0, core_auto = 1'b1;
  int   core_seen = 0, core_dly = 0;
  assign core_done = core_auto ? auto_val : man_val;

  initial forever begin
    @(posedge clk_50); #2;
    if (start_cnt != core_seen) begin
      core_seen = start_cnt;
      auto_val  = 1'b0;
      core_dly  = 50;
    end else if (core_dly > 0) begin
      core_dly--;
      if (core_dly == 0) auto_val = 1'b1;
    end
  end

  // ---------------- host sink ready ----------------
  int rdy_pct = 100;
  initial forever begin
    @(posedge clk_50); #2;
    m_ready = ($urandom_range(99, 0) < rdy_pct);
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 0);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] pix [MEMN];

  task automatic step();
    @(posedge clk_50); #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit hs;
    hs = 1'b0;
    s_valid = 1'b1;
    s_data  = b;
    for (int i = 0; i < 5000 && !hs; i++) begin
      @(negedge clk_50);
      hs = s_ready;
      step();
    end
    s_valid = 1'b0;
    if (!hs) begin
      n_cmp++; n_bad++;
      $display("FAIL send_byte: byte %0d not accepted within bound", b);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (n < 30000) begin
      @(negedge clk_50);
      if (!busy) break;
      n++;
    end
    step();
    if (n >= 30000) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_idle: busy still %0d, required 0", tag, busy);
    end
  endtask

  task automatic send_hdr(input int w, input int h);
    logic [15:0] wv, hv;
    wv = 16'(w);
    hv = 16'(h);
    send_byte(wv[7:0]); send_byte(wv[15:8]);
    send_byte(hv[7:0]); send_byte(hv[15:8]);
  endtask

  task automatic clear_mon();
    got_wa.delete(); got_wd.delete(); got_m.delete();
    bubbles = 0;
  endtask

  task automatic fill_mem_out();
    for (int i = 0; i < MEMN; i++) mem_out[i] = 8'($urandom);
  endtask

  task automatic check_out(input string tag, input int n_out);
    int nb;
    nb = 0;
    chk({tag, "_out_cnt"}, got_m.size(), n_out);
    for (int i = 0; i < got_m.size() && i < n_out; i++)
      if (got_m[i] !== mem_out[i]) nb++;
    chk({tag, "_out_data"}, nb, 0);
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_rst_outs"},
        {s_ready, in_we, core_start, m_valid, busy, err_size, img_w, img_h, out_raddr}, 0);
  endtask

  // One complete transfer; expectations come from the caller (table or model).
  task automatic run_xfer(input string tag, input int w, input int h, input int ow,
                          input int oh, input int pct, input bit exp_err,
                          input bit exp_st, input bit seq);
    int st0, n_in, n_out, nb;
    clear_mon();
    fill_mem_out();
    out_w = 16'(ow); out_h = 16'(oh);
    rdy_pct = pct;
    n_in  = exp_st ? w * h : 0;
    n_out = (exp_st && !exp_err) ? ow * oh : 0;
    exp_n_out = n_out;
    for (int i = 0; i < n_in; i++) pix[i] = seq ? 8'(i) : 8'($urandom);
    st0 = start_cnt;
    send_hdr(w, h);
    for (int i = 0; i < n_in; i++) send_byte(pix[i]);
    wait_idle(tag);
    chk({tag, "_err"}, err_size, exp_err);
    chk({tag, "_starts"}, start_cnt - st0, exp_st);
    chk({tag, "_wr_cnt"}, got_wa.size(), n_in);
    nb = 0;
    for (int i = 0; i < got_wa.size() && i < n_in; i++)
      if (got_wa[i] !== AW'(i) || got_wd[i] !== pix[i]) nb++;
    chk({tag, "_wr_data"}, nb, 0);
    if (exp_st) chk({tag, "_img_wh"}, {img_w, img_h}, {16'(w), 16'(h)});
    check_out(tag, n_out);
    if (pct == 100 && n_out > 0) chk({tag, "_bubbles"}, bubbles, 0);
  endtask

  function automatic bit dim_ok(input int a, input int b);
    return a > 0 && b > 0 && longint'(a) * longint'(b) <= longint'(MEMN);
  endfunction

  // ---------------- test ----------------
  typedef struct {
    int w, h, ow, oh, pct;
    bit err, st, seq;
  } vec_t;
  vec_t tv[9];

  initial begin
    int nr, st0;
    tv[0] = '{10, 10, 20, 20, 100, 1'b0, 1'b1, 1'b1};  // reference transfer
    tv[1] = '{ 0,  5,  4,  4, 100, 1'b1, 1'b0, 1'b0};  // zero width
    tv[2] = '{ 4,  3,  5,  7,  30, 1'b0, 1'b1, 1'b0};  // valid header clears err
    tv[3] = '{65, 64,  1,  1, 100, 1'b1, 1'b0, 1'b0};  // 4160 > 4096
    tv[4] = '{64, 64,  1,  1, 100, 1'b0, 1'b1, 1'b0};  // exactly 4096
    tv[5] = '{ 1,  1,  0,  3, 100, 1'b1, 1'b1, 1'b0};  // zero output size
    tv[6] = '{ 2,  2, 64, 65, 100, 1'b1, 1'b1, 1'b0};  // output too large
    tv[7] = '{ 3,  5, 16, 16,  30, 1'b0, 1'b1, 1'b0};  // 30% sink duty
    tv[8] = '{ 1,  1, 64, 64, 100, 1'b0, 1'b1, 1'b0};  // full-size dump

    #3;
    check_rst("por");
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk_50);
    chk("por_s_ready_before_edge", s_ready, 0);
    step();
    @(negedge clk_50);
    chk("por_s_ready_after_edge", s_ready, 1);
    step();

    for (int i = 0; i < 9; i++)
      run_xfer($sformatf("vec%0d", i), tv[i].w, tv[i].h, tv[i].ow, tv[i].oh,
               tv[i].pct, tv[i].err, tv[i].st, tv[i].seq);

    for (int k = 0; k < 6; k++) begin
      int w, h, ow, oh, pct;
      bit ok_in, ok_out;
      w  = $urandom_range(12, 0);
      h  = $urandom_range(12, 1);
      ow = $urandom_range(16, 0);
      oh = $urandom_range(16, 1);
      case ($urandom_range(2, 0))
        0: pct = 100;
        1: pct = 30;
        default: pct = 70;
      endcase
      ok_in  = dim_ok(w, h);
      ok_out = dim_ok(ow, oh);
      run_xfer($sformatf("rnd%0d", k), w, h, ow, oh, pct, !(ok_in && ok_out), ok_in, 1'b0);
    end

    // core_done held high across start: must wait for a fresh rising edge,
    // and bytes offered meanwhile are refused.
    core_auto = 1'b0; man_val = 1'b1;
    clear_mon(); fill_mem_out();
    out_w = 16'd2; out_h = 16'd2; rdy_pct = 100; exp_n_out = 4;
    st0 = start_cnt;
    send_hdr(2, 2);
    for (int i = 0; i < 4; i++) send_byte(8'(i + 1));
    nr = 0;
    s_valid = 1'b1; s_data = 8'hA5;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_50);
      if (s_ready) nr++;
      step();
    end
    s_valid = 1'b0;
    chk("held_s_ready_in_wait", nr, 0);
    chk("held_busy", busy, 1);
    chk("held_no_output", got_m.size(), 0);
    man_val = 1'b0;
    repeat (3) step();
    man_val = 1'b1;
    wait_idle("held");
    chk("held_starts", start_cnt - st0, 1);
    check_out("held", 4);
    core_auto = 1'b1;

    // reset in the middle of LOAD, after pixel index 36 is written
    clear_mon();
    exp_n_out = 0;
    send_hdr(10, 10);
    for (int i = 0; i < 37; i++) send_byte(8'(i));
    chk("midload_wr_cnt", got_wa.size(), 37);
    #1 rst_n = 1'b0;
    #1 check_rst("midload");
    step(); step();
    rst_n = 1'b1;
    @(negedge clk_50);
    chk("midload_s_ready_before_edge", s_ready, 0);
    step();
    @(negedge clk_50);
    chk("midload_s_ready_after_edge", s_ready, 1);
    step();
    run_xfer("after_load_rst", 10, 10, 6, 5, 70, 1'b0, 1'b1, 1'b0);

    // reset in the middle of DUMP
    clear_mon(); fill_mem_out();
    out_w = 16'd20; out_h = 16'd20; rdy_pct = 30; exp_n_out = 400;
    send_hdr(4, 4);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    nr = 0;
    while (got_m.size() < 10 && nr < 5000) begin
      @(negedge clk_50);
      nr++;
    end
    step();
    chk("middump_reached", got_m.size() >= 10, 1);
    #1 rst_n = 1'b0;
    #1 check_rst("middump");
    step(); step();
    rst_n = 1'b1;
    step(); step();
    run_xfer("after_dump_rst", 5, 4, 9, 9, 100, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
